calc_frame_driver: RTL and testbench
====================================

CALC_FRAME_DRIVER -- requirements
Module: calc_frame_driver

Interface
REQ-001 Parameter EXEC_WAIT, default 1, sets the number of cycles the ALU inputs are held before the result is sampled (legal range 1..15).
REQ-002 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  command byte valid.
REQ-006 in_ready  out  1  block accepts command byte.
REQ-007 in_data  in  8  command byte.
REQ-008 alu_opcode  out  3  opcode to external calculator.
REQ-009 alu_a  out  8  operand a to calculator.
REQ-010 alu_b  out  8  operand b to calculator.
REQ-011 alu_out  in  16  calculator result.
REQ-012 alu_carry  in  1  calculator carry flag.
REQ-013 alu_zero  in  1  calculator zero flag.
REQ-014 out_valid  out  1  response byte valid.
REQ-015 out_ready  in  1  downstream accepts response byte.
REQ-016 out_data  out  8  response byte.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err  out  1  one-cycle pulse on a malformed opcode byte.

Function
REQ-019 A byte transfer SHALL occur on a rising edge where valid and ready are both high; data and valid SHALL stay stable while ready is low.
REQ-020 A request frame SHALL be 3 bytes: opcode byte (bits[2:0] opcode, bits[7:3] zero), then a, then b.
REQ-021 The response frame SHALL be 3 bytes: result[15:8], result[7:0], then flag byte {5'b0, divzero, zero, carry}.
REQ-022 The FSM states SHALL be IDLE, GET_A, GET_B, EXEC, SEND_HI, SEND_LO, SEND_FLG.
REQ-023 in_ready SHALL be high only in IDLE, GET_A and GET_B; out_valid SHALL be high only in the SEND_* states.
REQ-024 IDLE SHALL advance to GET_A on an accepted opcode byte with bits[7:3]==0.
REQ-025 An opcode byte with any of bits[7:3] set SHALL be dropped and pulse err for one cycle, and the FSM SHALL stay in IDLE.
REQ-026 GET_A SHALL latch a and advance to GET_B.
REQ-027 GET_B SHALL latch b and advance to EXEC, except for opcode 3'b011 with b==0, which SHALL go directly to SEND_HI with result 16'hFFFF, divzero=1, zero=0, carry=0 and SHALL NOT sample the ALU.
REQ-028 alu_opcode, alu_a and alu_b SHALL be registered and held constant from the GET_B accept edge until the capture edge.
REQ-029 EXEC SHALL count EXEC_WAIT cycles; on the last EXEC cycle it SHALL capture alu_out, alu_carry and alu_zero, set divzero=0, and advance to SEND_HI.
REQ-030 SEND_HI SHALL go to SEND_LO, SEND_LO to SEND_FLG, and SEND_FLG to IDLE, each on an accepted out transfer; the FSM SHALL wait indefinitely under backpressure.
REQ-031 Latency from b accept to first out_valid SHALL be EXEC_WAIT+1 cycles, or 1 cycle on the divide-by-zero path.
REQ-032 Response bytes SHALL be registered, with no combinational path from in_* to out_*.
REQ-033 A new request SHALL NOT be accepted until SEND_FLG completes; the earliest acceptance is the cycle after the flag byte transfer.

Reset
REQ-034 While rst is high at a clock edge: state=IDLE; in_ready=1 after reset; out_valid=0, out_data=0, busy=0, err=0; alu_opcode/alu_a/alu_b=0; captured result, flags and wait counter=0.
REQ-035 A reset asserted mid-frame, in any state, SHALL discard the partial request or response with no residual output.

Structure
REQ-036 A shared package calc_pkg SHALL hold the 3-bit opcode constants (add 000, sub 001, mult 010, div 011, exp 100, square 101, negation 110, or 111) and the FSM state encoding.
REQ-037 The block SHALL be a single module with no sub-module; the calculator is external, connected via the alu_* ports.

Verification
REQ-038 Add: bytes 0x00,0x05,0x03 with the ALU model returning 0x0008, carry 0, zero 0 -> out 0x00, 0x08, 0x00.
REQ-039 Multiply: bytes 0x02,0xFF,0xFF with the ALU returning 0xFE01 -> out 0xFE, 0x01, 0x00; alu_a/alu_b stay at 0xFF until capture.
REQ-040 Divide by zero: bytes 0x03,0x10,0x00 -> out 0xFF, 0xFF, 0x04 one cycle after the b accept; the ALU is never sampled.
REQ-041 Bad opcode: byte 0x0A -> err high exactly one cycle, busy stays 0; the next bytes 0x01,0x09,0x04 (ALU returns 0x0005) -> out 0x00, 0x05, 0x00.
REQ-042 Backpressure: out_ready low for 5 cycles in SEND_HI -> out_data held at the hi byte and out_valid held high; no byte is lost or duplicated.
REQ-043 Reset mid-frame: rst asserted in GET_B -> next cycle state is IDLE, in_ready=1, out_valid=0; a following full frame completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode and FSM encodings for the calculator frame driver.
// Also holds the small helpers that map a state to its handshake outputs.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_MULT   = 3'b010,
    OP_DIV    = 3'b011,
    OP_EXP    = 3'b100,
    OP_SQUARE = 3'b101,
    OP_NEG    = 3'b110,
    OP_OR     = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SEND_HI  = 3'd4,
    ST_SEND_LO  = 3'd5,
    ST_SEND_FLG = 3'd6
  } state_e;

  localparam int          WAIT_W         = 4;
  localparam logic [15:0] DIVZERO_RESULT = 16'hFFFF;

  function automatic logic [7:0] flag_byte(input logic divz, input logic zero,
                                           input logic carry);
    return {5'b0, divz, zero, carry};
  endfunction

  function automatic logic takes_input(input state_e s);
    return (s == ST_IDLE) || (s == ST_GET_A) || (s == ST_GET_B);
  endfunction

  function automatic logic is_send(input state_e s);
    return (s == ST_SEND_HI) || (s == ST_SEND_LO) || (s == ST_SEND_FLG);
  endfunction

endpackage

// File: rtl/calc_frame_driver.sv
// Byte-stream front end for an external calculator: collects a 3-byte request,
// drives the ALU for EXEC_WAIT cycles, and returns a 3-byte response.
module calc_frame_driver
  import calc_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        err
);

  state_e              state_q, state_d;
  logic                in_ready_q, out_valid_q, busy_q, err_q;
  logic [7:0]          out_data_q;
  logic [2:0]          op_q;
  logic [7:0]          a_q;
  logic [2:0]          alu_opcode_q;
  logic [7:0]          alu_a_q, alu_b_q;
  logic [7:0]          result_lo_q;
  logic                divz_q, zero_q, carry_q;
  logic [WAIT_W-1:0]   wait_q;

  logic in_fire, out_fire, bad_op, div_by_zero, exec_done;

  always_comb begin
    in_fire     = in_valid && in_ready_q;
    out_fire    = out_valid_q && out_ready;
    bad_op      = |in_data[7:3];
    div_by_zero = (op_q == OP_DIV) && (in_data == 8'h00);
    exec_done   = (wait_q == '0);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (in_fire && !bad_op) state_d = ST_GET_A;
      ST_GET_A:    if (in_fire) state_d = ST_GET_B;
      ST_GET_B:    if (in_fire) state_d = div_by_zero ? ST_SEND_HI : ST_EXEC;
      ST_EXEC:     if (exec_done) state_d = ST_SEND_HI;
      ST_SEND_HI:  if (out_fire) state_d = ST_SEND_LO;
      ST_SEND_LO:  if (out_fire) state_d = ST_SEND_FLG;
      ST_SEND_FLG: if (out_fire) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      out_data_q   <= '0;
      op_q         <= '0;
      a_q          <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_lo_q  <= '0;
      divz_q       <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= takes_input(state_d);
      out_valid_q <= is_send(state_d);
      busy_q      <= (state_d != ST_IDLE);
      err_q       <= (state_q == ST_IDLE) && in_fire && bad_op;

      unique case (state_q)
        ST_IDLE: begin
          if (in_fire && !bad_op) op_q <= in_data[2:0];
        end
        ST_GET_A: begin
          if (in_fire) a_q <= in_data;
        end
        ST_GET_B: begin
          if (in_fire) begin
            alu_opcode_q <= op_q;
            alu_a_q      <= a_q;
            alu_b_q      <= in_data;
            wait_q       <= WAIT_W'(EXEC_WAIT - 1);
            if (div_by_zero) begin
              result_lo_q <= DIVZERO_RESULT[7:0];
              out_data_q  <= DIVZERO_RESULT[15:8];
              divz_q      <= 1'b1;
              zero_q      <= 1'b0;
              carry_q     <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            result_lo_q <= alu_out[7:0];
            out_data_q  <= alu_out[15:8];
            divz_q      <= 1'b0;
            zero_q      <= alu_zero;
            carry_q     <= alu_carry;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_SEND_HI: begin
          if (out_fire) out_data_q <= result_lo_q;
        end
        ST_SEND_LO: begin
          if (out_fire) out_data_q <= flag_byte(divz_q, zero_q, carry_q);
        end
        ST_SEND_FLG: begin
          if (out_fire) out_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_calc_frame_driver.sv
// Randomized self-checking bench for calc_frame_driver; a behavioural calculator
// drives the alu_* inputs and predicts each response frame from the request bytes.
module tb_calc_frame_driver;
  localparam int EW = 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy, err;
  logic        alu_carry, alu_zero;
  logic [7:0]  in_data, alu_a, alu_b, out_data;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_out;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  calc_frame_driver #(.EXEC_WAIT(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  // Calculator model: returns {carry, zero, result}
  function automatic logic [17:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'd0: begin r = 16'(a) + 16'(b); c = r[8]; end
      3'd1: begin r = 16'(a) - 16'(b); c = (a < b); end
      3'd2: r = 16'(a) * 16'(b);
      3'd3: r = (b == 8'h00) ? 16'h0000 : 16'(a / b);
      3'd4: r = 16'(a) << b[3:0];
      3'd5: r = 16'(a) * 16'(a);
      3'd6: r = -16'(a);
      default: r = 16'(a | b);
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_out} = alu_ref(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_frame(input logic [7:0] op_b, input logic [7:0] a_b,
                          input logic [7:0] b_b, input int stall_pct,
                          input int hold_hi, input string name);
    logic [7:0]  req[3];
    logic [7:0]  exp_b[3];
    logic [7:0]  got[3];
    logic [17:0] r;
    int idx, nrx, k, lat, hi_wait, hold_bad, excl_bad, exp_lat;
    bit b_done, sent, rcv, divz;
    req  = '{op_b, a_b, b_b};
    divz = (op_b[2:0] == 3'd3) && (b_b == 8'h00);
    if (divz) begin
      exp_b   = '{8'hFF, 8'hFF, 8'h04};
      exp_lat = 1;
    end else begin
      r       = alu_ref(op_b[2:0], a_b, b_b);
      exp_b   = '{r[15:8], r[7:0], {6'b0, r[16], r[17]}};
      exp_lat = EW + 1;
    end
    got = '{8'hxx, 8'hxx, 8'hxx};
    idx = 0; nrx = 0; k = 0; lat = -1; hi_wait = 0; hold_bad = 0; excl_bad = 0;
    b_done = 0;
    for (int cyc = 0; cyc < 300 && nrx < 3; cyc++) begin
      @(negedge clk);
      if (in_ready && out_valid) excl_bad++;
      if (b_done) begin
        k++;
        if (out_valid && lat < 0) lat = k;
        if (lat < 0 && (alu_a !== a_b || alu_b !== b_b || alu_opcode !== op_b[2:0]))
          hold_bad++;
      end
      if (idx < 3 && $urandom_range(99) >= 15) begin
        in_valid = 1'b1;
        in_data  = req[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (out_valid && nrx == 0 && hi_wait < hold_hi) begin
        out_ready = 1'b0;
        hi_wait++;
        if (out_data !== exp_b[0]) hold_bad++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      sent = in_valid && in_ready;
      rcv  = out_valid && out_ready;
      if (rcv) got[nrx] = out_data;
      @(posedge clk);
      if (sent) begin
        idx++;
        if (idx == 3) b_done = 1;
      end
      if (rcv) nrx++;
    end
    chk({name, "_bytes_rx"}, nrx, 3);
    for (int i = 0; i < 3; i++) chk({name, "_byte"}, got[i], exp_b[i]);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_alu_hold"}, hold_bad, 0);
    chk({name, "_in_out_excl"}, excl_bad, 0);
    if (hold_hi > 0) chk({name, "_hi_stall"}, hi_wait, hold_hi);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({name, "_ready_after"}, {in_ready, busy, out_valid}, 3'b100);
  endtask

  task automatic send_bad(input logic [7:0] byte_v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = byte_v;
    out_ready = 1'b0;
    chk("bad_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bad_err_pulse", err, 1);
    chk("bad_busy", busy, 0);
    @(negedge clk);
    chk("bad_err_clear", err, 0);
    chk("bad_busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", {out_valid, out_data}, 9'h000);
    chk("rst_busy_err", {busy, err}, 2'b00);
    chk("rst_alu", {alu_opcode, alu_a, alu_b}, 19'h0);
    rst = 1'b0;

    do_frame(8'h00, 8'h05, 8'h03, 0, 0, "add");
    do_frame(8'h02, 8'hFF, 8'hFF, 20, 0, "mult");
    do_frame(8'h03, 8'h10, 8'h00, 0, 0, "divzero");
    send_bad(8'h0A);
    do_frame(8'h01, 8'h09, 8'h04, 0, 0, "sub");
    do_frame(8'h00, 8'h80, 8'h90, 0, 5, "backpressure");

    // Reset while waiting for operand b
    @(negedge clk); in_valid = 1'b1; in_data = 8'h02;
    @(posedge clk);
    @(negedge clk); in_data = 8'h33;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("getb_before_rst", {busy, in_ready, out_valid}, 3'b110);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_out", {out_valid, out_data}, 9'h000);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu", {alu_opcode, alu_a, alu_b}, 19'h0);
    do_frame(8'h05, 8'h0C, 8'h00, 10, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op, a, b;
      if ($urandom_range(3) == 0) send_bad({5'($urandom_range(31, 1)), 3'($urandom)});
      op = {5'b0, 3'($urandom)};
      a  = 8'($urandom);
      b  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      do_frame(op, a, b, $urandom_range(60), $urandom_range(2), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
